vx_ecc_line_scrubber: RTL and testbench

//  Background ECC scrubber for one cache bank's Hamming-protected data store.
//  - Walks every line index in turn and issues a scrub read to the bank.
//  - Inspects the decoded response for that line:
//    - single-bit fault: writes the corrected line back;
//    - double fault: invalidates the line.
//  - Arbitrates with the bank pipeline through a req/gnt pair.
//  - Aborts a pending write-back if the pipeline writes the same line first.

---
 rtl/vx_ecc_line_scrubber.sv | 150 +++++++++++++++
 tb/tb_vx_ecc_line_scrubber.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ecc_line_scrubber.sv
// Background ECC scrubber: visits one line every SCRUB_INTERVAL idle cycles, reads it, then writes back or invalidates it.
// Each request is held on the req/gnt slot until it is granted. A pipeline write to the line under scrub aborts the visit.
module vx_ecc_line_scrubber #(
    parameter int LINE_COUNT     = 64,
    parameter int LINE_SEL_BITS  = $clog2(LINE_COUNT),
    parameter int LINE_WIDTH     = 128,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     req,
    output logic                     req_wr,
    output logic                     req_inv,
    output logic [LINE_SEL_BITS-1:0] req_addr,
    output logic [LINE_WIDTH-1:0]    req_data,
    input  logic                     gnt,
    input  logic                     rsp_valid,
    input  logic                     rsp_line_valid,
    input  logic                     rsp_corrected,
    input  logic                     rsp_dfault,
    input  logic [LINE_WIDTH-1:0]    rsp_data,
    input  logic                     snp_wr_valid,
    input  logic [LINE_SEL_BITS-1:0] snp_wr_addr,
    output logic [CNT_WIDTH-1:0]     corr_count,
    output logic [CNT_WIDTH-1:0]     dfault_count,
    output logic                     busy
);
    localparam int TMR_W = $clog2(SCRUB_INTERVAL + 1);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_WAIT_TMR,
        S_RD_REQ,
        S_RD_WAIT,
        S_WB_REQ,
        S_INV_REQ,
        S_NEXT
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [TMR_W-1:0]         r_tmr, w_tmr_nxt;
    logic [LINE_SEL_BITS-1:0] r_ptr;
    logic                     r_stale, w_stale_nxt;
    logic [LINE_WIDTH-1:0]    r_wb_data;
    logic [CNT_WIDTH-1:0]     r_corr_cnt, r_dfault_cnt;
    logic                     w_snp_hit, w_corr_inc, w_dfault_inc;

    assign w_snp_hit = snp_wr_valid && (snp_wr_addr == r_ptr);

    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_nxt    = r_tmr;
        w_stale_nxt  = r_stale;
        w_corr_inc   = 1'b0;
        w_dfault_inc = 1'b0;
        req          = 1'b0;
        req_wr       = 1'b0;
        req_inv      = 1'b0;
        case (r_state)
            S_WAIT_TMR: begin
                if (!enable) begin
                    w_tmr_nxt = '0;
                end else if (r_tmr == TMR_LAST) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_RD_REQ;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            S_RD_REQ: begin
                req = 1'b1;
                if (gnt) begin
                    w_state_nxt = S_RD_WAIT;
                    w_stale_nxt = 1'b0;
                end
            end
            S_RD_WAIT: begin
                if (rsp_valid) begin
                    w_stale_nxt  = 1'b0;
                    // Fault counts stand even when the visit is abandoned as stale.
                    w_dfault_inc = rsp_line_valid && rsp_dfault;
                    w_corr_inc   = rsp_line_valid && !rsp_dfault && rsp_corrected;
                    if (r_stale || w_snp_hit)
                        w_state_nxt = S_NEXT;
                    else if (w_dfault_inc)
                        w_state_nxt = S_INV_REQ;
                    else if (w_corr_inc)
                        w_state_nxt = S_WB_REQ;
                    else
                        w_state_nxt = S_NEXT;
                end else if (w_snp_hit) begin
                    w_stale_nxt = 1'b1;
                end
            end
            S_WB_REQ: begin
                req    = 1'b1;
                req_wr = 1'b1;
                // A snoop hit alongside gnt still lets the granted transfer go.
                if (gnt || w_snp_hit)
                    w_state_nxt = S_NEXT;
            end
            S_INV_REQ: begin
                req     = 1'b1;
                req_inv = 1'b1;
                if (gnt || w_snp_hit)
                    w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                w_state_nxt = S_WAIT_TMR;
            end
            default: begin
                w_state_nxt = S_WAIT_TMR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_WAIT_TMR;
            r_tmr        <= '0;
            r_ptr        <= '0;
            r_stale      <= 1'b0;
            r_wb_data    <= '0;
            r_corr_cnt   <= '0;
            r_dfault_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_stale <= w_stale_nxt;
            if (w_corr_inc)
                r_wb_data <= rsp_data;
            if (w_corr_inc && r_corr_cnt != CNT_MAX)
                r_corr_cnt <= r_corr_cnt + CNT_WIDTH'(1);
            if (w_dfault_inc && r_dfault_cnt != CNT_MAX)
                r_dfault_cnt <= r_dfault_cnt + CNT_WIDTH'(1);
            if (r_state == S_NEXT)
                r_ptr <= r_ptr + LINE_SEL_BITS'(1);
        end
    end

    assign req_addr     = r_ptr;
    assign req_data     = (r_state == S_WB_REQ) ? r_wb_data : '0;
    assign corr_count   = r_corr_cnt;
    assign dfault_count = r_dfault_cnt;
    assign busy         = (r_state != S_WAIT_TMR);

endmodule

// File: tb/tb_vx_ecc_line_scrubber.sv
// Scenario bench for vx_ecc_line_scrubber: a line-visit model predicts every bank transfer and counter value.
`timescale 1ns/1ps
module tb_vx_ecc_line_scrubber;
    localparam int LC   = 64;
    localparam int LSB  = 6;
    localparam int LW   = 128;
    localparam int SI   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic           wr;
        logic           inv;
        logic [LSB-1:0] addr;
        logic [LW-1:0]  data;
    } xfer_t;

    logic           clk = 1'b0;
    logic           reset, enable, gnt;
    logic           rsp_valid, rsp_line_valid, rsp_corrected, rsp_dfault;
    logic [LW-1:0]  rsp_data;
    logic           snp_wr_valid;
    logic [LSB-1:0] snp_wr_addr;
    logic           req, req_wr, req_inv, busy;
    logic [LSB-1:0] req_addr;
    logic [LW-1:0]  req_data;
    logic [CW-1:0]  corr_count, dfault_count;

    int    checks = 0;
    int    errors = 0;
    int    m_ptr = 0;
    int    m_corr = 0;
    int    m_dfault = 0;
    xfer_t xq[$];

    vx_ecc_line_scrubber #(
        .LINE_COUNT(LC), .LINE_WIDTH(LW), .SCRUB_INTERVAL(SI), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req(req), .req_wr(req_wr), .req_inv(req_inv), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_line_valid(rsp_line_valid),
        .rsp_corrected(rsp_corrected), .rsp_dfault(rsp_dfault), .rsp_data(rsp_data),
        .snp_wr_valid(snp_wr_valid), .snp_wr_addr(snp_wr_addr),
        .corr_count(corr_count), .dfault_count(dfault_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Every granted slot, as seen by the bank.
    always @(negedge clk)
        if (!reset && req && gnt)
            xq.push_back({req_wr, req_inv, req_addr, req_data});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // kind: 0 clean, 1 invalid line, 2 corrected, 3 dfault, 4 dfault+corrected
    // snp: 0 none, 1 hit in RD_WAIT, 2 hit in WB/INV without gnt, 3 hit with gnt, 4 miss
    task automatic do_visit(input int kind, input logic [LW-1:0] data, input int gnt_dly,
                            input int snp, input bit dis_mid);
        xfer_t exp_q[$];
        bit    lv, co, df, bad;
        int    act, n;
        xq.delete();
        lv = (kind != 1);
        co = (kind == 2 || kind == 4 || (kind == 1 && $urandom_range(0, 1) == 1));
        df = (kind >= 3 || (kind == 1 && $urandom_range(0, 1) == 1));
        act = !lv ? 0 : df ? 2 : co ? 1 : 0;
        if (gnt_dly == 0) gnt = 1'b1;
        n = 0;
        while (!req && n < 4 * SI + 10) begin
            step();
            n++;
        end
        checks++;
        if (req !== 1'b1) begin
            $display("FAIL rd_req_timeout: req=%b after %0d cycles, required 1", req, n);
            errors++;
            gnt = 1'b0;
            return;
        end
        checks++;
        if (req_wr !== 1'b0 || req_inv !== 1'b0 || req_addr !== LSB'(m_ptr)) begin
            $display("FAIL rd_req: wr=%b inv=%b addr=%0d, required 0 0 %0d", req_wr, req_inv, req_addr, m_ptr);
            errors++;
        end
        exp_q.push_back({1'b0, 1'b0, LSB'(m_ptr), {LW{1'b0}}});
        gnt = 1'b0;
        for (int i = 0; i < gnt_dly; i++) begin
            step();
            checks++;
            if (req !== 1'b1 || req_wr !== 1'b0 || req_inv !== 1'b0 || req_addr !== LSB'(m_ptr)) begin
                $display("FAIL rd_hold cycle %0d: req=%b wr=%b inv=%b addr=%0d, required 1 0 0 %0d",
                         i, req, req_wr, req_inv, req_addr, m_ptr);
                errors++;
            end
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        if (dis_mid) enable = 1'b0;
        if (snp == 1 || snp == 4) begin
            snp_wr_valid = 1'b1;
            snp_wr_addr  = (snp == 1) ? LSB'(m_ptr) : LSB'(m_ptr + 1 + $urandom_range(0, LC - 2));
            step();
            snp_wr_valid = 1'b0;
        end
        repeat ($urandom_range(0, 3)) step();
        rsp_valid = 1'b1; rsp_line_valid = lv; rsp_corrected = co; rsp_dfault = df; rsp_data = data;
        step();
        rsp_valid = 1'b0; rsp_data = rand_line(); rsp_line_valid = 1'b1; rsp_corrected = 1'b1; rsp_dfault = 1'b1;
        if (act == 1) m_corr = (m_corr < CMAX) ? m_corr + 1 : CMAX;
        if (act == 2) m_dfault = (m_dfault < CMAX) ? m_dfault + 1 : CMAX;
        if (act != 0 && snp != 1) begin
            checks++;
            if (req !== 1'b1 || req_wr !== (act == 1) || req_inv !== (act == 2) || req_addr !== LSB'(m_ptr)
                || req_data !== ((act == 1) ? data : {LW{1'b0}})) begin
                $display("FAIL fix_req: req=%b wr=%b inv=%b addr=%0d data=%h, required 1 %0d %0d %0d %h",
                         req, req_wr, req_inv, req_addr, req_data, act == 1, act == 2, m_ptr,
                         (act == 1) ? data : {LW{1'b0}});
                errors++;
            end
            if (snp == 2) begin
                snp_wr_valid = 1'b1;
                snp_wr_addr  = LSB'(m_ptr);
                step();
                snp_wr_valid = 1'b0;
            end else begin
                repeat ($urandom_range(0, 2)) step();
                gnt = 1'b1;
                if (snp == 3) begin
                    snp_wr_valid = 1'b1;
                    snp_wr_addr  = LSB'(m_ptr);
                end
                step();
                gnt = 1'b0;
                snp_wr_valid = 1'b0;
                exp_q.push_back({act == 1, act == 2, LSB'(m_ptr), (act == 1) ? data : {LW{1'b0}}});
            end
        end
        checks++;
        if (req !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL next_state line %0d: req=%b busy=%b, required 0 1", m_ptr, req, busy);
            errors++;
        end
        step();
        checks++;
        if (busy !== 1'b0 || corr_count !== CW'(m_corr) || dfault_count !== CW'(m_dfault)) begin
            $display("FAIL counters line %0d: busy=%b corr=%0d dfault=%0d, required 0 %0d %0d",
                     m_ptr, busy, corr_count, dfault_count, m_corr, m_dfault);
            errors++;
        end
        checks++;
        bad = (xq.size() != exp_q.size());
        for (int i = 0; i < xq.size() && !bad; i++)
            if (xq[i] !== exp_q[i]) bad = 1'b1;
        if (bad) begin
            $display("FAIL transfers line %0d: got %0d transfers (first %h), required %0d (first %h)",
                     m_ptr, xq.size(), (xq.size() > 0) ? xq[0] : '0, exp_q.size(), exp_q[0]);
            errors++;
        end
        m_ptr = (m_ptr + 1) % LC;
        if (dis_mid) enable = 1'b1;
    endtask

    task automatic advance_to(input int line);
        while (m_ptr != line) do_visit(0, rand_line(), 0, 0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; gnt = 1'b1; rsp_valid = 1'b0; rsp_line_valid = 1'b0;
        rsp_corrected = 1'b0; rsp_dfault = 1'b0; rsp_data = '0; snp_wr_valid = 1'b0; snp_wr_addr = '0;
        repeat (3) step();
        checks++;
        if ({req, req_wr, req_inv, req_addr, req_data, corr_count, dfault_count, busy} !== '0) begin
            $display("FAIL reset_state: req=%b wr=%b inv=%b addr=%0d data=%h corr=%0d df=%0d busy=%b, required all 0",
                     req, req_wr, req_inv, req_addr, req_data, corr_count, dfault_count, busy);
            errors++;
        end
        reset = 1'b0;
        gnt = 1'b0;
    endtask

    task automatic test_enable_timer();
        int reqs;
        reqs = 0;
        repeat (10) begin step(); reqs += (req || busy) ? 1 : 0; end
        enable = 1'b1;
        repeat (SI - 1) begin step(); reqs += (req || busy) ? 1 : 0; end
        enable = 1'b0;
        step(); reqs += (req || busy) ? 1 : 0;
        checks++;
        if (reqs != 0) begin
            $display("FAIL timer_gated: %0d active cycles with enable interrupted, required 0", reqs);
            errors++;
        end
        enable = 1'b1;
        repeat (SI - 1) begin step(); reqs += req ? 1 : 0; end
        checks++;
        if (reqs != 0) begin
            $display("FAIL timer_early: req seen %0d cycles before interval elapsed, required 0", reqs);
            errors++;
        end
        step();
        checks++;
        if (req !== 1'b1 || req_addr !== '0) begin
            $display("FAIL timer_fire: req=%b addr=%0d after %0d enabled cycles, required 1 0", req, req_addr, SI);
            errors++;
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i <= LC; i++) do_visit(0, rand_line(), 0, 0, 1'b0);
        checks++;
        if (m_corr != 0 || corr_count !== '0 || dfault_count !== '0) begin
            $display("FAIL wrap_counters: corr=%0d df=%0d, required 0 0", corr_count, dfault_count);
            errors++;
        end
    endtask

    task automatic test_corrected();
        logic [LW-1:0] pat;
        pat = {16{8'hA5}};
        advance_to(5);
        do_visit(2, pat, 1, 0, 1'b0);
    endtask

    task automatic test_dfault();
        advance_to(7);
        do_visit(4, rand_line(), 0, 0, 1'b0);
    endtask

    task automatic test_snoop_abort();
        advance_to(9);
        do_visit(2, rand_line(), 0, 2, 1'b0);
        checks++;
        if (m_ptr != 10 || corr_count !== CW'(2)) begin
            $display("FAIL snoop_abort: next line %0d corr=%0d, required 10 2", m_ptr, corr_count);
            errors++;
        end
    endtask

    task automatic test_gnt_stall();
        do_visit(0, rand_line(), 20, 0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) do_visit(2, rand_line(), 0, 0, 1'b0);
        checks++;
        if (corr_count !== CW'(CMAX)) begin
            $display("FAIL saturate: corr=%0d, required %0d", corr_count, CMAX);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (!req && n < 4 * SI + 10) begin step(); n++; end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rsp_valid = 1'b1; rsp_line_valid = 1'b1; rsp_corrected = 1'b1; rsp_dfault = 1'b0; rsp_data = rand_line();
        step();
        rsp_valid = 1'b0;
        checks++;
        if (req !== 1'b1 || req_wr !== 1'b1) begin
            $display("FAIL wb_before_reset: req=%b wr=%b, required 1 1", req, req_wr);
            errors++;
        end
        reset = 1'b1;
        step();
        checks++;
        if ({req, req_wr, req_inv, req_addr, req_data, corr_count, dfault_count, busy} !== '0) begin
            $display("FAIL reset_mid: req=%b wr=%b addr=%0d data=%h corr=%0d df=%0d busy=%b, required all 0",
                     req, req_wr, req_addr, req_data, corr_count, dfault_count, busy);
            errors++;
        end
        reset = 1'b0;
        m_ptr = 0; m_corr = 0; m_dfault = 0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rsp_valid = 1'b1; rsp_line_valid = 1'b1; rsp_dfault = 1'b1;
                step();
                rsp_valid = 1'b0;
            end
            do_visit($urandom_range(0, 4), rand_line(), $urandom_range(0, 3),
                     $urandom_range(0, 4), $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_enable_timer();
        test_wrap();
        test_corrected();
        test_dfault();
        test_snoop_abort();
        test_gnt_stall();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
